// File: rtl/int_reg_scoreboard_pkg.sv
// int_reg_scoreboard_pkg: shared types and sizing for the integer register scoreboard.
package int_reg_scoreboard_pkg;
  localparam int SB_NUM_REGS = 32;
  localparam int SB_CNT_W = 2;
  typedef logic [4:0] reg_idx_t;
  typedef struct packed {
    reg_idx_t rs1;
    reg_idx_t rs2;
    logic     rs1_used;
    logic     rs2_used;
  } sb_query_t;
endpackage

// File: rtl/int_reg_scoreboard_sb_counter.sv
// sb_counter: saturating-by-construction up/down counter; clear wins, inc+dec cancel.
module sb_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (inc && !dec) ? cnt_q + W'(1) : (dec && !inc) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
`ifdef FORMAL
  // Callers gate inc at max and dec at zero, so the counter never wraps.
  a_no_ovf: assert property (@(posedge clk) disable iff (rst) !(inc && !dec && !clr && cnt_q == '1));
  a_no_udf: assert property (@(posedge clk) disable iff (rst) !(dec && !inc && !clr && cnt_q == '0));
  c_max:    cover property (@(posedge clk) cnt_q == '1);
`endif
endmodule

// File: rtl/int_reg_scoreboard.sv
// int_reg_scoreboard: tracks in-flight multi-cycle writers per integer register and raises ID stalls.
module int_reg_scoreboard
  import int_reg_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = SB_NUM_REGS,
  parameter int CNT_W = SB_CNT_W
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_flush,
  input  logic          i_issue_valid,
  input  reg_idx_t      i_issue_rd,
  output logic          o_issue_ready,
  input  logic          i_complete_valid,
  input  reg_idx_t      i_complete_rd,
  input  reg_idx_t      i_rs1,
  input  reg_idx_t      i_rs2,
  input  logic          i_rs1_used,
  input  logic          i_rs2_used,
  output logic          o_rs1_busy,
  output logic          o_rs2_busy,
  output logic          o_stall,
  output logic          o_underflow_err
);
  localparam logic [CNT_W-1:0] MAX = '1;
  sb_query_t q;
  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic [CNT_W-1:0] issue_cnt, cmp_cnt, rs1_cnt, rs2_cnt;
  logic issue_acc, cmp_acc, err_q, err_d;
  assign q = '{rs1: i_rs1, rs2: i_rs2, rs1_used: i_rs1_used, rs2_used: i_rs2_used};
  assign cnt[0] = '0;
  genvar g;
  generate
    for (g = 1; g < NUM_REGS; g++) begin : g_cnt
      sb_counter #(.W(CNT_W)) u_cnt (
        .clk(i_clk),
        .rst(i_rst),
        .clr(i_flush),
        .inc(issue_acc && i_issue_rd == reg_idx_t'(g)),
        .dec(cmp_acc && i_complete_rd == reg_idx_t'(g)),
        .cnt(cnt[g])
      );
    end
  endgenerate
  // A same-cycle complete to the queried register is bypassed so the stall drops with zero latency.
  always_comb begin
    issue_cnt = cnt[i_issue_rd];
    cmp_cnt = cnt[i_complete_rd];
    rs1_cnt = cnt[q.rs1];
    rs2_cnt = cnt[q.rs2];
    o_issue_ready = issue_cnt != MAX || (i_complete_valid && i_complete_rd == i_issue_rd);
    issue_acc = i_issue_valid && o_issue_ready && i_issue_rd != '0 && !i_flush;
    cmp_acc = i_complete_valid && i_complete_rd != '0 && cmp_cnt != '0 && !i_flush;
    err_d = err_q || (i_complete_valid && i_complete_rd != '0 && cmp_cnt == '0 && !i_flush);
    o_rs1_busy = q.rs1 != '0 && rs1_cnt != '0 &&
                 !(rs1_cnt == CNT_W'(1) && i_complete_valid && i_complete_rd == q.rs1);
    o_rs2_busy = q.rs2 != '0 && rs2_cnt != '0 &&
                 !(rs2_cnt == CNT_W'(1) && i_complete_valid && i_complete_rd == q.rs2);
    o_stall = (o_rs1_busy && q.rs1_used) || (o_rs2_busy && q.rs2_used) || (!o_issue_ready && i_issue_valid);
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) err_q <= 1'b0;
    else err_q <= err_d;
  assign o_underflow_err = err_q;
`ifdef FORMAL
  a_rs1_x0: assert property (@(posedge i_clk) disable iff (i_rst) !(o_rs1_busy && q.rs1 == '0));
  a_rs2_x0: assert property (@(posedge i_clk) disable iff (i_rst) !(o_rs2_busy && q.rs2 == '0));
`endif
endmodule

// File: tb/tb_int_reg_scoreboard.sv
// tb_int_reg_scoreboard: directed-vector bench for int_reg_scoreboard with immediate-assertion checks.
module tb_int_reg_scoreboard;
  import int_reg_scoreboard_pkg::*;
  logic clk = 0, rst = 1, flush, iv, cv, u1, u2;
  reg_idx_t ird, crd, rs1, rs2;
  logic ready, b1, b2, stall, uerr;
  int n_cmp = 0, n_bad = 0;
  int_reg_scoreboard dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_issue_valid(iv), .i_issue_rd(ird), .o_issue_ready(ready),
    .i_complete_valid(cv), .i_complete_rd(crd),
    .i_rs1(rs1), .i_rs2(rs2), .i_rs1_used(u1), .i_rs2_used(u2),
    .o_rs1_busy(b1), .o_rs2_busy(b2), .o_stall(stall), .o_underflow_err(uerr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic idle();
    flush = 0; iv = 0; cv = 0; u1 = 0; u2 = 0;
    ird = '0; crd = '0; rs1 = '0; rs2 = '0;
  endtask
  task automatic next();
    @(negedge clk);
    idle();
  endtask
  initial begin
    idle();
    #1;
    chk("rst_ready", ready, 1'b1);
    chk("rst_stall", stall, 1'b0);
    chk("rst_err", uerr, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 0;
    // Issue rd=5; same-cycle read does not see it.
    next(); iv = 1; ird = 5; rs1 = 5; u1 = 1; #1;
    chk("iss5_ready", ready, 1'b1);
    chk("iss5_same_busy", b1, 1'b0);
    next(); rs1 = 5; u1 = 1; #1;
    chk("rs1_5_busy", b1, 1'b1);
    chk("rs1_5_stall", stall, 1'b1);
    next(); rs1 = 5; u1 = 1; cv = 1; crd = 5; #1;
    chk("cmp5_bypass_busy", b1, 1'b0);
    chk("cmp5_bypass_stall", stall, 1'b0);
    next(); rs1 = 5; u1 = 1; #1;
    chk("rs1_5_idle", b1, 1'b0);
    // Saturate rd=7.
    next(); iv = 1; ird = 7; #1; chk("iss7a_ready", ready, 1'b1);
    next(); iv = 1; ird = 7; #1; chk("iss7b_ready", ready, 1'b1);
    next(); iv = 1; ird = 7; #1; chk("iss7c_ready", ready, 1'b1);
    next(); iv = 1; ird = 7; #1;
    chk("iss7_full_ready", ready, 1'b0);
    chk("iss7_full_stall", stall, 1'b1);
    next(); iv = 1; ird = 7; cv = 1; crd = 7; rs2 = 7; u2 = 1; #1;
    chk("iss7_cmp_ready", ready, 1'b1);
    chk("rs2_7_busy_cnt3_cmp", b2, 1'b1);
    next(); iv = 1; ird = 7; #1;
    chk("cnt7_still_full", ready, 1'b0);
    // Issue+complete rd=9 from cnt=1.
    next(); iv = 1; ird = 9; #1;
    next(); iv = 1; ird = 9; cv = 1; crd = 9; rs2 = 9; u2 = 1; #1;
    chk("ic9_bypass_busy", b2, 1'b0);
    next(); rs2 = 9; u2 = 1; #1;
    chk("rs2_9_busy_after", b2, 1'b1);
    chk("rs2_9_stall", stall, 1'b1);
    // x0 complete is ignored without error; rs=0 never busy.
    next(); cv = 1; crd = 0; rs1 = 0; u1 = 1; #1;
    chk("rs1_x0_busy", b1, 1'b0);
    next(); #1;
    chk("x0_cmp_no_err", uerr, 1'b0);
    // Underflow on rd=12.
    next(); cv = 1; crd = 12; #1;
    chk("udf_same_cycle", uerr, 1'b0);
    next(); #1;
    chk("udf_next_cycle", uerr, 1'b1);
    // Build cnt[3]=2, cnt[4]=1 then flush with issue rd=3.
    next(); iv = 1; ird = 3; #1;
    next(); iv = 1; ird = 3; #1;
    next(); iv = 1; ird = 4; #1;
    next(); flush = 1; iv = 1; ird = 3; rs1 = 3; rs2 = 4; u1 = 1; u2 = 1; #1;
    chk("flush_cycle_rs1_3", b1, 1'b1);
    chk("flush_cycle_rs2_4", b2, 1'b1);
    next(); rs1 = 3; rs2 = 4; #1;
    chk("post_flush_rs1_3", b1, 1'b0);
    chk("post_flush_rs2_4", b2, 1'b0);
    chk("post_flush_err", uerr, 1'b1);
    next(); rs1 = 7; rs2 = 9; u1 = 1; u2 = 1; #1;
    chk("post_flush_rs1_7", b1, 1'b0);
    chk("post_flush_rs2_9", b2, 1'b0);
    chk("post_flush_stall", stall, 1'b0);
    next(); iv = 1; ird = 3; #1;
    next(); iv = 1; ird = 3; #1;
    next(); iv = 1; ird = 3; #1;
    next(); iv = 1; ird = 3; #1;
    chk("cnt3_refill_full", ready, 1'b0);
    // Async reset mid-run with cnt[5]=2.
    next(); iv = 1; ird = 5; #1;
    next(); iv = 1; ird = 5; #1;
    next(); rs1 = 5; u1 = 1; iv = 1; ird = 3; #1;
    chk("pre_rst_rs1_5", b1, 1'b1);
    rst = 1; #1;
    chk("async_rst_busy", b1, 1'b0);
    chk("async_rst_ready", ready, 1'b1);
    chk("async_rst_stall", stall, 1'b0);
    chk("async_rst_err", uerr, 1'b0);
    next(); rst = 0; rs1 = 5; u1 = 1; #1;
    chk("after_rst_rs1_5", b1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
